// File: rtl/jtag_scan_sequencer.sv
// JTAG TAP master: turns TAP-reset / IR-scan / DR-scan commands into registered
// TMS/TDI sequences and returns the TDO bits captured while in Shift.
module jtag_scan_sequencer #(
    parameter int DATA_W     = 150,
    parameter int LEN_W      = 8,
    parameter int RESET_ONES = 5
) (
    input  logic              clk,
    input  logic              TRST_b,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic              busy,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data
);
    typedef enum logic [2:0] {IDLE, RST_SEQ, PRE, SHIFT, POST, RESP} state_t;

    localparam logic [1:0]       T_RST    = 2'd0;
    localparam logic [1:0]       T_IR     = 2'd1;
    localparam logic [1:0]       T_RSV    = 2'd3;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] RST_LAST = LEN_W'(RESET_ONES);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] POST_END = LEN_W'(2);

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  last_idx;
    logic [LEN_W-1:0]  cap_idx;
    logic [DATA_W-1:0] data_q;
    logic              is_ir;
    logic              cap_en;
    logic              cmd_bad;
    logic [LEN_W-1:0]  pre_last;

    assign cmd_ready = (state == IDLE);
    assign cmd_bad   = (cmd_type == T_RSV) ||
                       ((cmd_type != T_RST) && ((cmd_len == '0) || (cmd_len > MAX_LEN)));
    assign pre_last  = is_ir ? LEN_W'(3) : LEN_W'(2);

    always_ff @(posedge clk or negedge TRST_b) begin
        if (!TRST_b) begin
            state     <= IDLE;
            cnt       <= '0;
            last_idx  <= '0;
            cap_idx   <= '0;
            data_q    <= '0;
            is_ir     <= 1'b0;
            cap_en    <= 1'b0;
            TMS       <= 1'b0;
            TDI       <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            // TMS/TDI set here drive the coming cycle; cap_en marks the cycle ending now as a shift cycle.
            if (cap_en) rsp_data[cap_idx] <= TDO;
            cap_en <= 1'b0;
            TMS    <= 1'b0;
            TDI    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        data_q   <= cmd_data;
                        last_idx <= cmd_len - ONE;
                        is_ir    <= (cmd_type == T_IR);
                        cnt      <= '0;
                        rsp_data <= '0;
                        if (cmd_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= (cmd_type == T_RST) ? RST_SEQ : PRE;
                        end
                    end
                end
                RST_SEQ: begin
                    if (cnt == RST_LAST + ONE) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        TMS <= (cnt < RST_LAST);
                        cnt <= cnt + ONE;
                    end
                end
                PRE: begin
                    // IR path walks Select-DR, Select-IR; DR path stops after Select-DR
                    TMS <= (cnt == '0) || (is_ir && (cnt == ONE));
                    if (cnt == pre_last) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                SHIFT: begin
                    TMS     <= (cnt == last_idx);
                    TDI     <= data_q[0];
                    data_q  <= data_q >> 1;
                    cap_en  <= 1'b1;
                    cap_idx <= cnt;
                    if (cnt == last_idx) begin
                        state <= POST;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                POST: begin
                    if (cnt == POST_END) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        TMS <= (cnt == '0);
                        cnt <= cnt + ONE;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
